// File: rtl/mmwave_pkt_pkg.sv
// rtl/mmwave_pkt_pkg.sv - Shared constants, FSM encoding and FIFO entry layout for the sample frame packer.
package mmwave_pkt_pkg;

    localparam logic [15:0] SYNC_WORD   = 16'hA5A5;
    localparam logic [15:0] TRAILER_TAG = 16'h5A5A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA_EVEN = 2'd1,
        ST_DATA_ODD  = 2'd2,
        ST_TRAILER   = 2'd3
    } pack_state_t;

    typedef struct packed {
        logic [31:0] word;
        logic        sof;
        logic        eof;
    } fifo_entry_t;

endpackage

// File: rtl/frame_word_fifo.sv
// rtl/frame_word_fifo.sv - Register-based show-ahead FIFO holding packed words with their sof/eof flags.
module frame_word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Head reads as zero when empty so the outputs are clean without resetting the array.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sample_frame_packer.sv
// rtl/sample_frame_packer.sv - Packs 13-bit samples into header/data(/trailer) 32-bit frames.
// Optional macro FRAME_CHECKSUM_EN adds a {TRAILER_TAG, sum} trailer word to each frame.
module sample_frame_packer
    import mmwave_pkt_pkg::*;
#(
    parameter int SAMPLES_PER_FRAME = 32,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        sample_valid_i,
    input  logic [12:0] sample_i,
    input  logic        word_ready_i,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic        sof_o,
    output logic        eof_o,
    output logic        overflow_o,
    output logic [15:0] frame_cnt_o
);

    localparam int PAIRS  = SAMPLES_PER_FRAME / 2;
    localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    pack_state_t  state, state_d;
    logic [12:0]  latch_q, latch_d;
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic [15:0]  frame_cnt, cnt_d;
    logic         overflow_q, ovf_d;
    logic         push;
    fifo_entry_t  push_entry;
    fifo_entry_t  head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_space;
    logic         last_pair;

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    localparam logic        LAST_DATA_EOF = 1'b0;
    localparam pack_state_t END_STATE     = ST_TRAILER;
`else
    localparam logic        LAST_DATA_EOF = 1'b1;
    localparam pack_state_t END_STATE     = ST_IDLE;
`endif

    // A push is possible when there is room, or when the head leaves in the same cycle.
    assign fifo_space = !fifo_full || (word_ready_i && !fifo_empty);
    assign last_pair  = (pair_q == PAIR_W'(PAIRS - 1));

    always_comb begin
        state_d    = state;
        latch_d    = latch_q;
        pair_d     = pair_q;
        cnt_d      = frame_cnt;
        ovf_d      = overflow_q;
        push       = 1'b0;
        push_entry = '0;
`ifdef FRAME_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state)
            ST_IDLE: begin
                if (sample_valid_i && en_i) begin
                    if (fifo_space) begin
                        push            = 1'b1;
                        push_entry.word = {SYNC_WORD, frame_cnt};
                        push_entry.sof  = 1'b1;
                        latch_d         = sample_i;
                        pair_d          = '0;
`ifdef FRAME_CHECKSUM_EN
                        sum_d           = {3'b000, sample_i};
`endif
                        state_d         = ST_DATA_ODD;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_DATA_ODD: begin
                if (sample_valid_i) begin
                    if (fifo_space) begin
                        push            = 1'b1;
                        push_entry.word = {3'b000, sample_i, 3'b000, latch_q};
                        push_entry.eof  = last_pair && LAST_DATA_EOF;
`ifdef FRAME_CHECKSUM_EN
                        sum_d           = sum_q + {3'b000, sample_i};
`endif
                        if (last_pair) begin
                            cnt_d   = frame_cnt + 16'd1;
                            state_d = END_STATE;
                        end else begin
                            pair_d  = pair_q + 1'b1;
                            state_d = ST_DATA_EVEN;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_DATA_EVEN: begin
                if (sample_valid_i) begin
                    latch_d = sample_i;
`ifdef FRAME_CHECKSUM_EN
                    sum_d   = sum_q + {3'b000, sample_i};
`endif
                    state_d = ST_DATA_ODD;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_TRAILER: begin
                if (sample_valid_i) ovf_d = 1'b1;
                if (fifo_space) begin
                    push            = 1'b1;
                    push_entry.word = {TRAILER_TAG, sum_q};
                    push_entry.eof  = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // frame_cnt doubles as the header sequence number; both advance together at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            latch_q    <= '0;
            pair_q     <= '0;
            frame_cnt  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_d;
            latch_q    <= latch_d;
            pair_q     <= pair_d;
            frame_cnt  <= cnt_d;
            overflow_q <= ovf_d;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end
`endif

    frame_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (34)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (word_ready_i),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head)
    );

    assign word_valid_o = !fifo_empty;
    assign word_o       = head.word;
    assign sof_o        = head.sof;
    assign eof_o        = head.eof;
    assign overflow_o   = overflow_q;
    assign frame_cnt_o  = frame_cnt;

endmodule

// File: tb/tb_sample_frame_packer.sv
// tb/tb_sample_frame_packer.sv - Self-checking bench: frame table plus overflow, en-drop and reset sequences.
module tb_sample_frame_packer;

    localparam int SPF = 32;
    localparam int FD  = 8;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        sample_valid_i;
    logic [12:0] sample_i;
    logic        word_ready_i = 1'b1;
    logic        word_valid_o;
    logic [31:0] word_o;
    logic        sof_o;
    logic        eof_o;
    logic        overflow_o;
    logic [15:0] frame_cnt_o;

    sample_frame_packer #(
        .SAMPLES_PER_FRAME (SPF),
        .FIFO_DEPTH        (FD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .word_ready_i   (word_ready_i),
        .word_valid_o   (word_valid_o),
        .word_o         (word_o),
        .sof_o          (sof_o),
        .eof_o          (eof_o),
        .overflow_o     (overflow_o),
        .frame_cnt_o    (frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        sof;
        logic        eof;
    } exp_t;

    typedef struct {
        logic [12:0] start;
        logic [12:0] stride;
        logic        en;
        logic        throttle;
        logic [15:0] exp_cnt;
    } vec_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          ready_mode  = 1'b0;
    bit          ready_force = 1'b1;
    int          cyc = 0;
    bit          sv_q = 1'b0;

    bit          m_in_frame = 1'b0;
    int          m_idx = 0;
    logic [15:0] m_seq = '0;
    logic [15:0] m_sum = '0;
    logic [12:0] m_prev = '0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        word_ready_i = ready_mode ? (cyc % 3 != 2) : ready_force;
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1)
            assert (!(sample_valid_i && sv_q)) else $error("sample_valid_i pulses closer than 2 cycles");
        sv_q <= sample_valid_i;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && word_valid_o && word_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word actual=%h sof=%b eof=%b required=none", word_o, sof_o, eof_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({word_o, sof_o, eof_o} !== {e.w, e.sof, e.eof}) begin
                    failures++;
                    $display("FAIL word actual=%h/%b/%b required=%h/%b/%b",
                             word_o, sof_o, eof_o, e.w, e.sof, e.eof);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [12:0] v);
        sample_valid_i = 1'b1;
        sample_i       = v;
        step();
        sample_valid_i = 1'b0;
        step();
    endtask

    task automatic model_sample(input logic [12:0] v, input logic en);
        if (!m_in_frame) begin
            if (!en) return;
            exp_q.push_back('{{16'hA5A5, m_seq}, 1'b1, 1'b0});
            m_in_frame = 1'b1;
            m_idx      = 0;
            m_sum      = '0;
        end
        m_sum = m_sum + {3'b000, v};
        if (m_idx % 2 == 1)
            exp_q.push_back('{{3'b000, v, 3'b000, m_prev}, 1'b0, (m_idx == SPF - 1) && !CK});
        else
            m_prev = v;
        if (m_idx == SPF - 1) begin
            m_seq++;
            m_in_frame = 1'b0;
            if (CK) exp_q.push_back('{{16'h5A5A, m_sum}, 1'b0, 1'b1});
        end
        m_idx++;
    endtask

    task automatic drive(input logic [12:0] v);
        model_sample(v, en_i);
        send(v);
    endtask

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            if (exp_q.size() == 0 && !word_valid_o) break;
            step();
        end
        checks++;
        if (exp_q.size() != 0 || word_valid_o) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_pending required=0", name, exp_q.size());
        end
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{13'd0,    13'd1,    1'b1, 1'b0, 16'd1};
        tbl[1] = '{13'd0,    13'd1,    1'b1, 1'b0, 16'd2};
        tbl[2] = '{13'h1FFF, 13'h1FFF, 1'b1, 1'b1, 16'd3};
        tbl[3] = '{13'd100,  13'd37,   1'b0, 1'b0, 16'd3};
        tbl[4] = '{13'd5,    13'd1000, 1'b1, 1'b1, 16'd4};

        rst_n          = 1'b0;
        en_i           = 1'b0;
        sample_valid_i = 1'b0;
        sample_i       = '0;
        step();
        step();
        chk("rst_word_valid", {31'd0, word_valid_o}, 32'd0);
        chk("rst_word",       word_o, 32'd0);
        chk("rst_sof",        {31'd0, sof_o}, 32'd0);
        chk("rst_eof",        {31'd0, eof_o}, 32'd0);
        chk("rst_overflow",   {31'd0, overflow_o}, 32'd0);
        chk("rst_frame_cnt",  {16'd0, frame_cnt_o}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int t = 0; t < 5; t++) begin
            ready_mode = tbl[t].throttle;
            en_i       = tbl[t].en;
            for (int i = 0; i < SPF; i++) begin
                logic [12:0] v;
                v = tbl[t].start + 13'(i) * tbl[t].stride;
                drive(v);
            end
            wait_drain($sformatf("tbl%0d", t));
            chk($sformatf("tbl%0d_frame_cnt", t), {16'd0, frame_cnt_o}, {16'd0, tbl[t].exp_cnt});
            chk($sformatf("tbl%0d_overflow", t), {31'd0, overflow_o}, 32'd0);
        end
        ready_mode = 1'b0;

        en_i = 1'b1;
        for (int i = 0; i < SPF; i++) begin
            if (i == 6) en_i = 1'b0;
            drive(13'(i + 300));
        end
        for (int i = 0; i < 4; i++) drive(13'(i + 50));
        wait_drain("en_drop");
        chk("en_drop_frame_cnt", {16'd0, frame_cnt_o}, {16'd0, m_seq});
        chk("en_drop_overflow", {31'd0, overflow_o}, 32'd0);

        ready_force = 1'b0;
        en_i        = 1'b1;
        step();
        for (int i = 0; i < 15; i++) drive(13'(i));
        chk("full_no_overflow_yet", {31'd0, overflow_o}, 32'd0);
        send(13'd15);
        chk("overflow_set", {31'd0, overflow_o}, 32'd1);
        chk("full_word_valid", {31'd0, word_valid_o}, 32'd1);
        ready_force = 1'b1;
        for (int i = 16; i <= SPF; i++) drive(13'(i));
        wait_drain("overflow");
        chk("overflow_sticky", {31'd0, overflow_o}, 32'd1);
        chk("overflow_frame_cnt", {16'd0, frame_cnt_o}, {16'd0, m_seq});

        ready_force = 1'b0;
        step();
        for (int i = 0; i <= 10; i++) send(13'(i));
        rst_n = 1'b0;
        #4;
        chk("mid_rst_word_valid", {31'd0, word_valid_o}, 32'd0);
        chk("mid_rst_word",       word_o, 32'd0);
        chk("mid_rst_sof",        {31'd0, sof_o}, 32'd0);
        chk("mid_rst_eof",        {31'd0, eof_o}, 32'd0);
        chk("mid_rst_overflow",   {31'd0, overflow_o}, 32'd0);
        chk("mid_rst_frame_cnt",  {16'd0, frame_cnt_o}, 32'd0);
        step();
        rst_n = 1'b1;
        exp_q.delete();
        m_seq       = '0;
        m_in_frame  = 1'b0;
        ready_force = 1'b1;
        step();
        for (int i = 0; i < SPF; i++) drive(13'(i));
        wait_drain("after_reset");
        chk("after_reset_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
